controle_multiciclo: RTL
========================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clock  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  start request, sampled only in state T0.
REQ-005 instruction  input  9  encoded instruction III_XXX_YYY (III=[8:6] opcode, XXX=[5:3] dest Rx, YYY=[2:0] source Ry).
REQ-006 registers_in  output  7  one-hot write enables to the 7-entry register bank (bit n writes Rn from data_bus).
REQ-007 register_out  output  3  read-select of the register bank driving its output onto the datapath.
REQ-008 ir_in  output  1  internal IR load strobe, exported for observation.
REQ-009 din_out  output  1  selects the immediate (external data input) onto data_bus.
REQ-010 ain  output  1  load enable of ALU operand register A.
REQ-011 gin  output  1  load enable of ALU result register G.
REQ-012 gout  output  1  selects G onto data_bus.
REQ-013 addsub  output  1  ALU operation, 0=add, 1=sub.
REQ-014 done  output  1  one-cycle pulse marking the final cycle of an instruction.

Function
REQ-015 Block SHALL be a 4-state FSM T0,T1,T2,T3 with an internal 9-bit IR; all outputs combinational decodes of state and IR only (no input-to-output paths except ir_in from run in T0).
REQ-016 Opcodes: 000 mv Rx<-Ry; 001 mvi Rx<-immediate; 010 add Rx<-Rx+Ry; 011 sub Rx<-Rx-Ry; 100-111 illegal.
REQ-017 Illegal: opcode 1xx, or XXX=7, or YYY=7 for mv/add/sub (register 7 does not exist); mvi ignores YYY.
REQ-018 T0: ir_in=run; on run=1 IR<=instruction and next state T1; run=0 stays T0; all other outputs 0.
REQ-019 T1 mv: register_out=Y, registers_in[X]=1, done=1, next T0.
REQ-020 T1 mvi: din_out=1, registers_in[X]=1, done=1, next T0.
REQ-021 T1 add/sub: register_out=X, ain=1, next T2.
REQ-022 T2 add/sub: register_out=Y, gin=1, addsub=(opcode==011), next T3.
REQ-023 T3 add/sub: gout=1, registers_in[X]=1, done=1, next T0.
REQ-024 T1 illegal: done=1, registers_in=0 and all enables 0, next T0 (no architectural effect).
REQ-025 Latency: mv/mvi/illegal 2 cycles from run sample to done; add/sub 4 cycles.
REQ-026 registers_in SHALL be zero or exactly one-hot in every cycle; never asserted in T0 or T2.
REQ-027 At most one of register_out-driven / din_out / gout SHALL source data_bus in any write cycle.
REQ-028 run and instruction SHALL be ignored outside T0; IR SHALL hold stable from T1 through T3.
REQ-029 register_out SHALL be 0 whenever not explicitly driven above.
REQ-030 Back-to-back: run=1 in the T0 following done SHALL start the next instruction with no bubble beyond T0.

Reset
REQ-031 reset=1 SHALL immediately force state T0 and IR=0, independent of clock.
REQ-032 During and after reset all outputs 0 (ir_in follows run only after reset deasserts).
REQ-033 Reset mid-instruction (T1-T3) SHALL abort it with no further registers_in pulse; done not asserted.

Verification
REQ-034 Reset, run=1, instruction=001_010_000 -> T1: din_out=1, registers_in=7'b0000100, done=1; next cycle T0.
REQ-035 mv 000_101_011 -> T1: register_out=3, registers_in=7'b0100000, done=1.
REQ-036 sub 011_001_100 -> T1 register_out=1 ain=1; T2 register_out=4 gin=1 addsub=1; T3 gout=1 registers_in=7'b0000010 done=1.
REQ-037 Illegal 000_111_010 and 101_000_000 -> T1 done=1, registers_in=0, no other enables.
REQ-038 add started, instruction changed and run toggled during T1-T3 -> sequence uses latched IR; reset asserted in T2 -> outputs 0 at once, no T3 write.
REQ-039 Random legal stream with run held high -> registers_in always one-hot-or-zero, done count equals instructions issued.

Source files
------------

// File: rtl/controle_multiciclo.sv
// -----------------------------------------------------------------------------
// controle_multiciclo
//
// Multicycle control unit for a tiny register-bank processor. A 4-state FSM
// (T0..T3) latches a 9-bit instruction III_XXX_YYY into an internal IR when
// 'run' is sampled high in T0. It then sequences the datapath enables:
//   000 mv  Rx <- Ry        (T1, done)
//   001 mvi Rx <- immediate (T1, done)
//   010 add Rx <- Rx + Ry   (T1 A<-Rx, T2 G<-A+Ry, T3 Rx<-G, done)
//   011 sub Rx <- Rx - Ry   (same as add with addsub=1)
//   1xx, Rx=7, or Ry=7 (except mvi) are illegal: T1 pulses done only.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   run          start request, sampled only in T0
//   instruction  encoded instruction III_XXX_YYY
//   registers_in one-hot write enables of R0..R6
//   register_out read-select of the register bank onto the datapath
//   ir_in        IR load strobe (mirrors run in T0)
//   din_out      selects the immediate onto data_bus
//   ain          load enable of operand register A
//   gin          load enable of result register G
//   gout         selects G onto data_bus
//   addsub       ALU operation, 0 = add, 1 = sub
//   done         one-cycle pulse on the last cycle of an instruction
//
// Outputs are combinational decodes of state and IR; the only input-to-output
// path is ir_in, which follows run while in T0.
// -----------------------------------------------------------------------------
module controle_multiciclo (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [8:0] instruction,
    output logic [6:0] registers_in,
    output logic [2:0] register_out,
    output logic       ir_in,
    output logic       din_out,
    output logic       ain,
    output logic       gin,
    output logic       gout,
    output logic       addsub,
    output logic       done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t     r_state;
    logic [8:0] r_ir;

    logic [2:0] w_opcode;
    logic [2:0] w_rx;
    logic [2:0] w_ry;
    logic       w_isMv;
    logic       w_isMvi;
    logic       w_isAddSub;
    logic       w_illegal;
    logic [6:0] w_rxOneHot;

    assign w_opcode   = r_ir[8:6];
    assign w_rx       = r_ir[5:3];
    assign w_ry       = r_ir[2:0];
    assign w_isMv     = (w_opcode == 3'b000);
    assign w_isMvi    = (w_opcode == 3'b001);
    assign w_isAddSub = (w_opcode == 3'b010) || (w_opcode == 3'b011);

    // Register 7 does not exist, so any reference to it is illegal; mvi has
    // no source register and therefore ignores YYY.
    assign w_illegal  = w_opcode[2]
                     || (w_rx == 3'd7)
                     || (!w_isMvi && (w_ry == 3'd7));

    // Shifting by 7 pushes the bit out, but illegal instructions never use
    // this decode anyway.
    assign w_rxOneHot = 7'b000_0001 << w_rx;

    // State and IR. The IR only loads in T0, so it stays stable T1..T3
    // regardless of what happens on 'instruction'.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= T0;
            r_ir    <= 9'd0;
        end else begin
            case (r_state)
                T0: begin
                    if (run) begin
                        r_ir    <= instruction;
                        r_state <= T1;
                    end
                end
                T1: begin
                    if (w_isAddSub && !w_illegal) begin
                        r_state <= T2;
                    end else begin
                        r_state <= T0;
                    end
                end
                T2:      r_state <= T3;
                T3:      r_state <= T0;
                default: r_state <= T0;
            endcase
        end
    end

    // Output decode. Everything defaults to zero so that only one bus source
    // and at most one register write enable is active in any cycle.
    always_comb begin
        registers_in = 7'd0;
        register_out = 3'd0;
        ir_in        = 1'b0;
        din_out      = 1'b0;
        ain          = 1'b0;
        gin          = 1'b0;
        gout         = 1'b0;
        addsub       = 1'b0;
        done         = 1'b0;
        case (r_state)
            T0: begin
                // Gated by reset so the strobe stays low while reset is held.
                ir_in = run && !reset;
            end
            T1: begin
                if (w_illegal) begin
                    done = 1'b1;
                end else if (w_isMv) begin
                    register_out = w_ry;
                    registers_in = w_rxOneHot;
                    done         = 1'b1;
                end else if (w_isMvi) begin
                    din_out      = 1'b1;
                    registers_in = w_rxOneHot;
                    done         = 1'b1;
                end else begin
                    register_out = w_rx;
                    ain          = 1'b1;
                end
            end
            T2: begin
                register_out = w_ry;
                gin          = 1'b1;
                addsub       = (w_opcode == 3'b011);
            end
            T3: begin
                gout         = 1'b1;
                registers_in = w_rxOneHot;
                done         = 1'b1;
            end
            default: begin
                registers_in = 7'd0;
            end
        endcase
    end

endmodule
